// File: rtl/mux_pkg.sv
// Shared types and helpers for the stream multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin pointer after a grant on channel ptr, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first requesting channel at or after ptr, wrapping.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_vld
);

  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0]   sum;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot       = N_CH'({req, req} >> ptr);
    grant_vld = |rot;
    off       = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SEL_W + 1)'(N_CH)) sum = sum - (SEL_W + 1)'(N_CH);
    grant = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready multiplexer with a registered output slot,
// software-selected or round-robin channel choice.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mux_mode_e         mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_ch
);

  // Index space padded to a power of two so an out-of-range sel reads as "not valid".
  localparam int PAD_W = 2 ** SEL_W;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_vld;
  logic [PAD_W-1:0] valid_pad;
  logic [PAD_W-1:0] ready_pad;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             load_en;
  logic             xfer;
  logic [W-1:0]     data_sel;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_vld (rr_vld)
  );

  assign valid_pad = PAD_W'(in_valid);
  assign load_en   = !out_valid || out_ready;

  // Mode mux, handshake decode and data select.
  always_comb begin
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_vld = rr_vld;
    end else begin
      grant     = sel;
      grant_vld = valid_pad[sel];
    end
    xfer      = rst_n && load_en && grant_vld;
    ready_pad = '0;
    if (xfer) ready_pad[grant] = 1'b1;
    data_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) data_sel = in_data[i*W +: W];
    end
  end

  assign in_ready = ready_pad[N_CH-1:0];

  // Output slot and round-robin pointer; pointer only advances on RR transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_data  <= data_sel;
      out_ch    <= grant;
      out_valid <= 1'b1;
      if (mode == MODE_RR) rr_ptr <= SEL_W'(rr_next(32'(grant), N_CH));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8-channel and a 5-channel instance.
module tb_stream_mux_rr;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-channel instance
  mux_mode_e   mode;
  logic [2:0]  sel;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ch;

  // 5-channel instance
  mux_mode_e   mode5;
  logic [2:0]  sel5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic        out_ready5;
  logic [2:0]  out_ch5;

  int vectors = 0;
  int miscompares = 0;

  stream_mux_rr #(.N_CH(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch)
  );

  stream_mux_rr #(.N_CH(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_ch(out_ch5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = MODE_SEL; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    mode5 = MODE_SEL; sel5 = 3'd0; in_valid5 = 5'h00; out_ready5 = 1'b1;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(8'h50 + i);
    tick(); tick();
    vectors++; if (in_ready !== 8'h00) begin miscompares++; $display("FAIL rst_in_ready: got %h want 00", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    #2 rst_n = 1'b1;
    // load a word on channel 5 and hold it with back-pressure
    in_data[5*8 +: 8] = 8'h5A; sel = 3'd5; in_valid = 8'h20; out_ready = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    vectors++; if (out_ch !== 3'd5) begin miscompares++; $display("FAIL rst_pre_ch: got %0d want 5", out_ch); end
    in_valid = 8'hFF; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    vectors++; if (out_ch !== 3'd0) begin miscompares++; $display("FAIL rst_mid_ch: got %0d want 0", out_ch); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_data: got %h want 00", out_data); end
    vectors++; if (in_ready !== 8'h00) begin miscompares++; $display("FAIL rst_mid_in_ready: got %h want 00", in_ready); end
    tick();
    in_valid = 8'h00; in_data[5*8 +: 8] = 8'h15;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sel();
    mode = MODE_SEL; sel = 3'd5; in_data[5*8 +: 8] = 8'hA5; in_valid = 8'h20; out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 8'h20) begin miscompares++; $display("FAIL sel_in_ready: got %h want 20", in_ready); end
    tick();
    vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL sel_data: got %h want a5", out_data); end
    vectors++; if (out_ch !== 3'd5) begin miscompares++; $display("FAIL sel_ch: got %0d want 5", out_ch); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sel_valid: got %b want 1", out_valid); end
    // selected channel idle while another is valid: no grant, slot drains, data held
    in_valid = 8'h08;
    #1;
    vectors++; if (in_ready !== 8'h00) begin miscompares++; $display("FAIL sel_idle_ready: got %h want 00", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sel_drain_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL sel_hold_data: got %h want a5", out_data); end
    vectors++; if (out_ch !== 3'd5) begin miscompares++; $display("FAIL sel_hold_ch: got %0d want 5", out_ch); end
    in_data[5*8 +: 8] = 8'h15;
  endtask

  task automatic test_rr_scan();
    logic [7:0] exp_ready;
    mode = MODE_RR; in_valid = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_ready = 8'h01 << (k % 8);
      vectors++; if (in_ready !== exp_ready) begin miscompares++; $display("FAIL rr_scan_ready[%0d]: got %h want %h", k, in_ready, exp_ready); end
      tick();
      vectors++; if (out_ch !== 3'(k % 8)) begin miscompares++; $display("FAIL rr_scan_ch[%0d]: got %0d want %0d", k, out_ch, k % 8); end
      vectors++; if (out_data !== 8'(8'h10 + (k % 8))) begin miscompares++; $display("FAIL rr_scan_data[%0d]: got %h want %h", k, out_data, 8'(8'h10 + (k % 8))); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rr_scan_valid[%0d]: got %b want 1", k, out_valid); end
    end
  endtask

  task automatic test_rr_wrap();
    // pointer is 2 after the scan; a grant on 2 moves it to 3
    mode = MODE_RR; out_ready = 1'b1; in_valid = 8'h04;
    tick();
    vectors++; if (out_ch !== 3'd2) begin miscompares++; $display("FAIL wrap_setup_ch: got %0d want 2", out_ch); end
    in_valid = 8'b1000_0100;
    #1;
    vectors++; if (in_ready !== 8'h80) begin miscompares++; $display("FAIL wrap_first_ready: got %h want 80", in_ready); end
    tick();
    vectors++; if (out_ch !== 3'd7) begin miscompares++; $display("FAIL wrap_first_ch: got %0d want 7", out_ch); end
    vectors++; if (in_ready !== 8'h04) begin miscompares++; $display("FAIL wrap_second_ready: got %h want 04", in_ready); end
    tick();
    vectors++; if (out_ch !== 3'd2) begin miscompares++; $display("FAIL wrap_second_ch: got %0d want 2", out_ch); end
    in_valid = 8'hFF;
    #1;
    vectors++; if (in_ready !== 8'h08) begin miscompares++; $display("FAIL wrap_ptr3_ready: got %h want 08", in_ready); end
    tick();
    // pointer now 4; a SEL-mode transfer must not move it
    mode = MODE_SEL; sel = 3'd0;
    tick();
    vectors++; if (out_ch !== 3'd0) begin miscompares++; $display("FAIL wrap_sel_ch: got %0d want 0", out_ch); end
    mode = MODE_RR;
    #1;
    vectors++; if (in_ready !== 8'h10) begin miscompares++; $display("FAIL wrap_ptr_held_ready: got %h want 10", in_ready); end
    tick();
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_back_pressure();
    mode = MODE_SEL; sel = 3'd1; in_data[1*8 +: 8] = 8'h11; in_valid = 8'h02; out_ready = 1'b0;
    tick();
    vectors++; if (out_data !== 8'h11) begin miscompares++; $display("FAIL bp_load_data: got %h want 11", out_data); end
    in_data[1*8 +: 8] = 8'h22; sel = 3'd3; in_data[3*8 +: 8] = 8'h33; in_valid = 8'h0A;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (in_ready !== 8'h00) begin miscompares++; $display("FAIL bp_stall_ready[%0d]: got %h want 00", k, in_ready); end
      tick();
      vectors++; if (out_data !== 8'h11) begin miscompares++; $display("FAIL bp_stall_data[%0d]: got %h want 11", k, out_data); end
      vectors++; if (out_valid !== 1'b1 || out_ch !== 3'd1) begin miscompares++; $display("FAIL bp_stall_ctl[%0d]: got v=%b ch=%0d want v=1 ch=1", k, out_valid, out_ch); end
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 8'h08) begin miscompares++; $display("FAIL bp_release_ready: got %h want 08", in_ready); end
    tick();
    vectors++; if (out_data !== 8'h33 || out_ch !== 3'd3) begin miscompares++; $display("FAIL bp_release_word: got %h/%0d want 33/3", out_data, out_ch); end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_nch5();
    mode5 = MODE_SEL; sel5 = 3'd2; in_valid5 = 5'h04; out_ready5 = 1'b0;
    tick();
    vectors++; if (out_valid5 !== 1'b1 || out_data5 !== 8'h52) begin miscompares++; $display("FAIL n5_load: got v=%b d=%h want v=1 d=52", out_valid5, out_data5); end
    sel5 = 3'd6; in_valid5 = 5'h1F;
    #1;
    vectors++; if (in_ready5 !== 5'h00) begin miscompares++; $display("FAIL n5_stall_ready: got %h want 00", in_ready5); end
    tick();
    out_ready5 = 1'b1;
    #1;
    vectors++; if (in_ready5 !== 5'h00) begin miscompares++; $display("FAIL n5_oor_ready: got %h want 00", in_ready5); end
    vectors++; if (out_valid5 !== 1'b1) begin miscompares++; $display("FAIL n5_pending_valid: got %b want 1", out_valid5); end
    tick();
    vectors++; if (out_valid5 !== 1'b0) begin miscompares++; $display("FAIL n5_drain_valid: got %b want 0", out_valid5); end
    vectors++; if (out_data5 !== 8'h52 || out_ch5 !== 3'd2) begin miscompares++; $display("FAIL n5_hold: got %h/%0d want 52/2", out_data5, out_ch5); end
    // round robin wraps at 5, not at 8
    mode5 = MODE_RR; in_valid5 = 5'h10;
    tick();
    vectors++; if (out_ch5 !== 3'd4) begin miscompares++; $display("FAIL n5_rr_ch4: got %0d want 4", out_ch5); end
    in_valid5 = 5'h1F;
    #1;
    vectors++; if (in_ready5 !== 5'h01) begin miscompares++; $display("FAIL n5_rr_wrap_ready: got %h want 01", in_ready5); end
    tick();
    vectors++; if (out_ch5 !== 3'd0 || out_data5 !== 8'h50) begin miscompares++; $display("FAIL n5_rr_wrap_word: got %0d/%h want 0/50", out_ch5, out_data5); end
    in_valid5 = 5'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_sel();
    test_rr_scan();
    test_rr_wrap();
    test_back_pressure();
    test_nch5();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
